// File: rtl/clint_timer_soft_int.sv
// Core-local interruptor: mtime/mtimecmp timer and msip software interrupt, 32-bit bus halves.
// Latency: request sampled at edge N answers with a one-cycle ready/rdata/bus_err at N+1; irqs lag registers by one cycle.
// Backpressure: none; every access completes in one cycle and back-to-back requests are accepted.
module clint_timer_soft_int #(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int unsigned PRESCALE    = 1,
  parameter logic [63:0] MTIME_RESET = 64'h0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] addr,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        bus_err,
  output logic        timer_int,
  output logic        soft_int,
  output logic        timer_int_clear,
  output logic        soft_int_clear
);

  // Register offsets inside the 64 KiB window.
  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

  // Terminal value of the prescale counter; the tick fires on this count.
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  // Architectural state.
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [15:0] presc_q, presc_d;

  // Bus response registers.
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        bus_err_q, bus_err_d;

  // Interrupt lines and their falling-edge pulses.
  logic timer_int_q, timer_int_d;
  logic soft_int_q, soft_int_d;
  logic timer_int_clear_q, timer_int_clear_d;
  logic soft_int_clear_q, soft_int_clear_d;

  // Decode results.
  logic        in_window;
  logic        sel_msip;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;
  logic        sel_mtime_lo;
  logic        sel_mtime_hi;
  logic        hit;
  logic        req;
  logic        conflict;
  logic        rd_ok;
  logic        wr_ok;
  logic        tick;
  logic [31:0] rd_mux;

  assign in_window = (addr[31:16] == BASE_ADDR[31:16]);
  assign req       = ren | wen;
  assign conflict  = ren & wen;

  // Address decode: one-hot register select, all zero outside the window or on a hole.
  always_comb begin
    sel_msip     = 1'b0;
    sel_cmp_lo   = 1'b0;
    sel_cmp_hi   = 1'b0;
    sel_mtime_lo = 1'b0;
    sel_mtime_hi = 1'b0;
    if (in_window) begin
      case (addr[15:0])
        OFF_MSIP:     sel_msip     = 1'b1;
        OFF_CMP_LO:   sel_cmp_lo   = 1'b1;
        OFF_CMP_HI:   sel_cmp_hi   = 1'b1;
        OFF_MTIME_LO: sel_mtime_lo = 1'b1;
        OFF_MTIME_HI: sel_mtime_hi = 1'b1;
        default:      ;
      endcase
    end
  end

  assign hit   = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mtime_lo | sel_mtime_hi;
  // A simultaneous read and write is an error and must have no side effects.
  assign rd_ok = ren & ~wen & hit;
  assign wr_ok = wen & ~ren & hit;
  assign tick  = (presc_q == PRESC_LAST);

  // Timebase: prescaled 64-bit increment; a software write to either half wins over the tick
  // and restarts the prescaler so the next increment is a full period after the write.
  always_comb begin
    presc_d = tick ? 16'h0 : presc_q + 16'd1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_ok && sel_mtime_lo) begin
      mtime_d = {mtime_q[63:32], wdata};
      presc_d = 16'h0;
    end else if (wr_ok && sel_mtime_hi) begin
      mtime_d = {wdata, mtime_q[31:0]};
      presc_d = 16'h0;
    end
  end

  // Compare register and software-interrupt bit writes; only msip bit 0 is storage.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_ok && sel_cmp_lo) begin
      mtimecmp_d = {mtimecmp_q[63:32], wdata};
    end
    if (wr_ok && sel_cmp_hi) begin
      mtimecmp_d = {wdata, mtimecmp_q[31:0]};
    end
    if (wr_ok && sel_msip) begin
      msip_d = wdata[0];
    end
  end

  // Read mux over current register contents, so an mtime read sees the pre-tick value.
  always_comb begin
    rd_mux = 32'h0;
    if (sel_msip)     rd_mux = {31'h0, msip_q};
    if (sel_cmp_lo)   rd_mux = mtimecmp_q[31:0];
    if (sel_cmp_hi)   rd_mux = mtimecmp_q[63:32];
    if (sel_mtime_lo) rd_mux = mtime_q[31:0];
    if (sel_mtime_hi) rd_mux = mtime_q[63:32];
  end

  // Bus response: every request completes next cycle; errors and writes return zero data.
  always_comb begin
    ready_d   = req;
    bus_err_d = req & (conflict | ~hit);
    rdata_d   = rd_ok ? rd_mux : 32'h0;
  end

  // Interrupt generation from settled register values, plus one-cycle pulses on each fall.
  always_comb begin
    timer_int_d       = (mtime_q >= mtimecmp_q);
    soft_int_d        = msip_q;
    timer_int_clear_d = timer_int_q & ~timer_int_d;
    soft_int_clear_d  = soft_int_q & ~soft_int_d;
  end

  // Architectural registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mtime_q    <= MTIME_RESET;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      presc_q    <= 16'h0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      presc_q    <= presc_d;
    end
  end

  // Bus response registers; reset drops any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rdata_q   <= 32'h0;
      ready_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Interrupt output registers; cleared with reset so no pulse appears on reset release.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      timer_int_q       <= 1'b0;
      soft_int_q        <= 1'b0;
      timer_int_clear_q <= 1'b0;
      soft_int_clear_q  <= 1'b0;
    end else begin
      timer_int_q       <= timer_int_d;
      soft_int_q        <= soft_int_d;
      timer_int_clear_q <= timer_int_clear_d;
      soft_int_clear_q  <= soft_int_clear_d;
    end
  end

  assign rdata           = rdata_q;
  assign ready           = ready_q;
  assign bus_err         = bus_err_q;
  assign timer_int       = timer_int_q;
  assign soft_int        = soft_int_q;
  assign timer_int_clear = timer_int_clear_q;
  assign soft_int_clear  = soft_int_clear_q;

endmodule

// File: doc/clint_timer_soft_int.md
Name: clint_timer_soft_int

Overview:
- Core-local interruptor. Memory-mapped machine timer (mtime/mtimecmp) and machine software-interrupt (msip) registers.
- Drives the timer and software interrupt request and clear lines into the core interrupt interface, which the privileged unit consumes as mip.MTIP/MSIP.
- Sits directly upstream of the privileged block, on the data-bus side of the core.
- RV32: 64-bit registers are accessed as two 32-bit halves.

Parameters:
- BASE_ADDR, 32'h0200_0000, base of the 64 KiB register window.
- PRESCALE, 1, core clocks per mtime increment; legal range 1..65535.
- MTIME_RESET, 64'h0, reset value of mtime.

Ports:
- CLK  in  1  core clock
- nRST  in  1  asynchronous active-low reset
- addr  in  32  bus byte address (word aligned)
- ren  in  1  read request, single-cycle strobe
- wen  in  1  write request, single-cycle strobe
- wdata  in  32  write data
- rdata  out  32  read data, valid when ready=1
- ready  out  1  access-complete pulse
- bus_err  out  1  error pulse; unmapped address or ren&wen together
- timer_int  out  1  machine timer interrupt pending (MTIP)
- soft_int  out  1  machine software interrupt pending (MSIP)
- timer_int_clear  out  1  one-cycle pulse on timer_int falling edge
- soft_int_clear  out  1  one-cycle pulse on soft_int falling edge

Behaviour:
- Clock and reset: one clock, CLK; nRST is asynchronous and active-low. Every flop resets asynchronously.
- Reset values: mtime=MTIME_RESET; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; msip=0; prescale counter=0; rdata=0; ready=0; bus_err=0; timer_int=0; soft_int=0; both clear pulses=0.
- Register map (offsets from BASE_ADDR):
  - 0x0000 msip: bit0 RW, bits 31:1 read 0, writes to them ignored.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
- Address decode:
  - Any other offset, or an address outside the window, completes with ready=1, bus_err=1, rdata=0. No state changes.
  - ren and wen high in the same cycle: ready=1, bus_err=1, no write, rdata=0.
- Access latency:
  - Request sampled at edge N. ready, rdata and bus_err are valid for exactly one cycle, N+1.
  - Back-to-back requests on consecutive cycles are legal; each receives its own ready pulse.
- Write effect: the register updates at edge N. A read at N+1 returns the new value.
- Timebase:
  - The prescale counter counts 0..PRESCALE-1. tick is asserted when the counter equals PRESCALE-1; the counter then wraps to 0.
  - On tick, mtime <= mtime+1, full 64-bit add. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A write to either mtime half takes priority over tick in that cycle. The other half is unchanged; there is no carry from the written half. The prescale counter resets to 0.
  - With PRESCALE=1, mtime increments every cycle.
- Half-access rules:
  - Software is responsible for the hi/lo/hi read sequence. No hardware snapshot.
  - A read of mtime low returns the value held before any tick at that edge.
- Interrupt generation:
  - timer_int is registered: timer_int <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on post-update register values. Result appears 1 cycle after mtime or mtimecmp changes.
  - soft_int is the registered msip bit0. It follows a write with 1-cycle delay.
- Clear pulses:
  - timer_int_clear=1 for the single cycle after timer_int goes 1->0 (e.g. mtimecmp rewritten above mtime). soft_int_clear behaves the same way for soft_int.
  - No pulse at reset deassertion.
- Reset mid-operation: an access in flight is dropped, with no ready pulse. All interrupt and clear outputs drop immediately with reset.

Test Plan:
- Reset, PRESCALE=1, MTIME_RESET=0, idle 10 cycles: read 0xBFF8 returns the value matching the cycle count; timer_int=0 (cmp all-ones); soft_int=0.
- Write mtimecmp lo=0x20, then hi=0. Expect timer_int to rise exactly 1 cycle after mtime reaches 0x20. Write mtimecmp lo=0xFFFF_FFFF: timer_int falls and timer_int_clear pulses for 1 cycle.
- Write 0x0000=1: soft_int=1 two cycles after the write request. Write 0: soft_int=0 and a soft_int_clear pulse. Write 0xFFFF_FFFE: soft_int stays 0 and a read returns 0.
- Carry: write mtime lo=0xFFFF_FFFE and hi=0x5. After 2 ticks, read hi=0x6 and lo=0x0. Then set mtime to all-ones; the next tick gives mtime=0.
- PRESCALE=4: mtime increments every 4th cycle. A write to mtime lo=0x100 at prescale count 2 gives the next increment 4 cycles after the write.
- Read 0x1000 -> ready=1, bus_err=1, rdata=0. ren&wen both high to 0x4000 -> bus_err=1 and mtimecmp is unchanged. Assert nRST mid-read -> no ready pulse and all outputs reach their reset values.
